// File: rtl/sdlib_pkg.sv
// sdlib_pkg: shared state encodings, clog2 helper and delay constant for the sdlib blocks
package sdlib_pkg;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} pack_state_e;
  localparam int SDLIB_DELAY = 0;
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= v) return r;
    return 32;
  endfunction
endpackage

// File: rtl/sd_pack_acc.sv
// sd_pack_acc: lane accumulator for sd_pack_n; stores narrow words at lane cnt and presents
// the packed wide word with every lane above the closing lane forced to zero
module sd_pack_acc
  import sdlib_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4,
  localparam int AW = clog2(ratio)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_i,
  input  logic                   inc_i,
  input  logic                   clr_i,
  input  logic                   hold_i,
  input  logic [width-1:0]       data_i,
  output logic [AW-1:0]          cnt_o,
  output logic [width*ratio-1:0] word_o
);
  logic [ratio-1:0][width-1:0] acc_q, acc_d;
  logic [AW-1:0] cnt_q, cnt_d;
  always_comb begin
    acc_d = acc_q;
    if (wr_i) acc_d[cnt_q] = data_i;
    cnt_d = clr_i ? '0 : inc_i ? cnt_q + AW'(1) : cnt_q;
  end
  // closing lane comes straight from the input unless it was parked in storage (HOLD)
  always_comb begin
    word_o = '0;
    for (int i = 0; i < ratio; i++)
      word_o[i*width +: width] = (i < int'(cnt_q)) ? acc_q[i] :
                                 (i == int'(cnt_q)) ? (hold_i ? acc_q[i] : data_i) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/sd_pack_n.sv
// sd_pack_n: srdy/drdy width up-converter packing ratio narrow words into one wide word.
// Define SDLIB_PACK_LAST_EN to add the c_last port for closing a wide word early.
module sd_pack_n
  import sdlib_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        c_srdy,
  output logic                        c_drdy,
  input  logic [width-1:0]            c_data,
`ifdef SDLIB_PACK_LAST_EN
  input  logic                        c_last,
`endif
  output logic                        p_srdy,
  input  logic                        p_drdy,
  output logic [width*ratio-1:0]      p_data,
  output logic [clog2(ratio+1)-1:0]   p_count
);
  localparam int AW = clog2(ratio);
  localparam int CW = clog2(ratio+1);
  pack_state_e state_q, state_d;
  logic last, accept, closing, out_free, load;
  logic [AW-1:0] acc_cnt;
  logic [width*ratio-1:0] packed_word;
  logic p_srdy_q, p_srdy_d;
  logic [width*ratio-1:0] p_data_q, p_data_d;
  logic [CW-1:0] p_count_q, p_count_d;
`ifdef SDLIB_PACK_LAST_EN
  assign last = c_last;
`else
  assign last = 1'b0;
`endif
  assign c_drdy   = (state_q == FILL);
  assign accept   = c_srdy & c_drdy;
  assign closing  = accept & (last | (acc_cnt == AW'(ratio - 1)));
  assign out_free = !p_srdy_q | p_drdy;
  assign load     = (closing & out_free) | ((state_q == HOLD) & p_drdy);
  sd_pack_acc #(.width(width), .ratio(ratio)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (accept),
    .inc_i  (accept & !closing),
    .clr_i  (load),
    .hold_i (state_q == HOLD),
    .data_i (c_data),
    .cnt_o  (acc_cnt),
    .word_o (packed_word)
  );
  // in HOLD acc_cnt still points at the closing lane, so count is acc_cnt+1 in both paths
  always_comb begin
    state_d   = (closing & !out_free) ? HOLD : ((state_q == HOLD) & p_drdy) ? FILL : state_q;
    p_srdy_d  = load | (p_srdy_q & !p_drdy);
    p_data_d  = load ? packed_word : p_data_q;
    p_count_d = load ? CW'(acc_cnt) + CW'(1) : p_count_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= FILL;
      p_srdy_q  <= 1'b0;
      p_data_q  <= '0;
      p_count_q <= '0;
    end else begin
      state_q   <= state_d;
      p_srdy_q  <= p_srdy_d;
      p_data_q  <= p_data_d;
      p_count_q <= p_count_d;
    end
  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign p_count = p_count_q;
endmodule

// File: tb/tb_sd_pack_n.sv
// tb_sd_pack_n: vector table, corner sequences and randomized scoreboard for sd_pack_n
// at ratio 4 and ratio 3 (width 8); c_last checks build only with SDLIB_PACK_LAST_EN.
module tb_sd_pack_n;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic c_srdy4, c_drdy4, p_srdy4, p_drdy4;
  logic [7:0] c_data4;
  logic [31:0] p_data4;
  logic [2:0] p_count4;
  logic c_srdy3, c_drdy3, p_srdy3, p_drdy3;
  logic [7:0] c_data3;
  logic [23:0] p_data3;
  logic [1:0] p_count3;
`ifdef SDLIB_PACK_LAST_EN
  logic c_last4, c_last3;
`endif
  int tests = 0, fails = 0;

  sd_pack_n #(.width(8), .ratio(4)) dut4 (
    .clk(clk), .reset(reset), .c_srdy(c_srdy4), .c_drdy(c_drdy4), .c_data(c_data4),
`ifdef SDLIB_PACK_LAST_EN
    .c_last(c_last4),
`endif
    .p_srdy(p_srdy4), .p_drdy(p_drdy4), .p_data(p_data4), .p_count(p_count4));
  sd_pack_n #(.width(8), .ratio(3)) dut3 (
    .clk(clk), .reset(reset), .c_srdy(c_srdy3), .c_drdy(c_drdy3), .c_data(c_data3),
`ifdef SDLIB_PACK_LAST_EN
    .c_last(c_last3),
`endif
    .p_srdy(p_srdy3), .p_drdy(p_drdy3), .p_data(p_data3), .p_count(p_count3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic c_srdy; logic [7:0] c_data; logic p_drdy;
    logic c_drdy; logic p_srdy; logic [31:0] p_data; logic [2:0] p_count;
  } vec_t;
  vec_t vt[$];

  logic [7:0] q4[$], q3[$];
  logic [31:0] e4, h4;
  logic [23:0] e3, h3;
  logic st4, st3;
  int n4, n3, cyc;

  initial begin
    reset = 1'b1;
    {c_srdy4, p_drdy4, c_srdy3, p_drdy3} = '0;
    c_data4 = '0;
    c_data3 = '0;
`ifdef SDLIB_PACK_LAST_EN
    c_last4 = 1'b0;
    c_last3 = 1'b0;
`endif
    @(negedge clk);
    chk("reset c_drdy", 32'(c_drdy4), 32'd1);
    chk("reset p_srdy", 32'(p_srdy4), 32'd0);
    chk("reset p_data", p_data4, 32'h0);
    chk("reset p_count", 32'(p_count4), 32'd0);
    chk("reset p_srdy r3", 32'(p_srdy3), 32'd0);
    reset = 1'b0;
    // back-to-back stream with free output, then the same stream into a stalled output
    vt.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h08070605, 3'd4});
    vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
    vt.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h04030201, 3'd4});
    vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h08070605, 3'd4});
    vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      c_srdy4 = vt[i].c_srdy;
      c_data4 = vt[i].c_data;
      p_drdy4 = vt[i].p_drdy;
      chk($sformatf("vec%0d c_drdy", i), 32'(c_drdy4), 32'(vt[i].c_drdy));
      chk($sformatf("vec%0d p_srdy", i), 32'(p_srdy4), 32'(vt[i].p_srdy));
      if (vt[i].p_srdy) begin
        chk($sformatf("vec%0d p_data", i), p_data4, vt[i].p_data);
        chk($sformatf("vec%0d p_count", i), 32'(p_count4), 32'(vt[i].p_count));
      end
    end
`ifdef SDLIB_PACK_LAST_EN
    @(negedge clk);
    {c_srdy4, c_data4, c_last4, p_drdy4} = {1'b1, 8'hAA, 1'b0, 1'b1};
    @(negedge clk);
    {c_data4, c_last4} = {8'hBB, 1'b1};
    @(negedge clk);
    c_data4 = 8'hCC;
    chk("last2 p_srdy", 32'(p_srdy4), 32'd1);
    chk("last2 p_data", p_data4, 32'h0000BBAA);
    chk("last2 p_count", 32'(p_count4), 32'd2);
    @(negedge clk);
    {c_srdy4, c_last4} = 2'b00;
    chk("last1 p_srdy", 32'(p_srdy4), 32'd1);
    chk("last1 p_data", p_data4, 32'h000000CC);
    chk("last1 p_count", 32'(p_count4), 32'd1);
`endif
    // reset with one wide word pending and two lanes accumulated
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {c_srdy4, c_data4, p_drdy4} = {1'b1, 8'(8'h20 + i), 1'b0};
    end
    @(negedge clk);
    c_srdy4 = 1'b0;
    chk("pre-reset p_srdy", 32'(p_srdy4), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset p_srdy", 32'(p_srdy4), 32'd0);
    chk("async reset p_count", 32'(p_count4), 32'd0);
    chk("async reset p_data", p_data4, 32'h0);
    chk("async reset c_drdy", 32'(c_drdy4), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {c_srdy4, c_data4, p_drdy4} = {1'b1, 8'(8'h31 + i), 1'b1};
    end
    @(negedge clk);
    c_srdy4 = 1'b0;
    chk("post-reset p_srdy", 32'(p_srdy4), 32'd1);
    chk("post-reset p_data", p_data4, 32'h34333231);
    chk("post-reset p_count", 32'(p_count4), 32'd4);
    @(negedge clk);
    // random traffic on both ratios against an in-order word scoreboard
    {n4, n3, cyc, st4, st3} = '0;
    while ((n4 < 10000 || n3 < 10002 || q4.size() != 0 || q3.size() != 0 || p_srdy4 || p_srdy3)
           && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (st4) begin
        chk("stall4 p_srdy", 32'(p_srdy4), 32'd1);
        chk("stall4 p_data", p_data4, h4);
      end
      if (st3) begin
        chk("stall3 p_srdy", 32'(p_srdy3), 32'd1);
        chk("stall3 p_data", 32'(p_data3), 32'(h3));
      end
      c_srdy4 = (n4 < 10000) && ($urandom_range(3) != 0);
      c_srdy3 = (n3 < 10002) && ($urandom_range(3) != 0);
      c_data4 = 8'($urandom);
      c_data3 = 8'($urandom);
      p_drdy4 = $urandom_range(3) != 0;
      p_drdy3 = $urandom_range(3) != 0;
      if (c_srdy4 && c_drdy4) begin q4.push_back(c_data4); n4++; end
      if (c_srdy3 && c_drdy3) begin q3.push_back(c_data3); n3++; end
      if (p_srdy4 && p_drdy4) begin
        chk("rand4 depth", 32'(q4.size() >= 4), 32'd1);
        e4 = '0;
        for (int i = 0; i < 4; i++) if (q4.size() != 0) e4 |= 32'(q4.pop_front()) << (8 * i);
        chk("rand4 p_data", p_data4, e4);
        chk("rand4 p_count", 32'(p_count4), 32'd4);
      end
      if (p_srdy3 && p_drdy3) begin
        chk("rand3 depth", 32'(q3.size() >= 3), 32'd1);
        e3 = '0;
        for (int i = 0; i < 3; i++) if (q3.size() != 0) e3 |= 24'(q3.pop_front()) << (8 * i);
        chk("rand3 p_data", 32'(p_data3), 32'(e3));
        chk("rand3 p_count", 32'(p_count3), 32'd3);
      end
      st4 = p_srdy4 && !p_drdy4;
      st3 = p_srdy3 && !p_drdy3;
      h4 = p_data4;
      h3 = p_data3;
    end
    {c_srdy4, c_srdy3} = 2'b00;
    chk("rand cycle budget", 32'(cyc < 40000), 32'd1);
    chk("rand4 leftover words", 32'(q4.size()), 32'd0);
    chk("rand3 leftover words", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
